// File: rtl/viterbi_pkg.sv
// Shared Viterbi defaults and trellis helpers: code-bit parity and the
// expected {c0,c1} pair for a branch register.
package viterbi_pkg;

   localparam int unsigned K      = 3;
   localparam int unsigned G0     = 'o7;
   localparam int unsigned G1     = 'o5;
   localparam int unsigned SOFT_W = 3;
   localparam int unsigned BM_W   = SOFT_W + 1;

   // Pair encoding is {c0, c1}: PAIR_10 means c0=1, c1=0.
   typedef enum logic [1:0] {
      PAIR_00 = 2'b00,
      PAIR_01 = 2'b01,
      PAIR_10 = 2'b10,
      PAIR_11 = 2'b11
   } pair_e;

   function automatic logic parity(input logic [31:0] v);
      return ^v;
   endfunction

   function automatic pair_e code_pair(input int unsigned r,
                                       input int unsigned g0,
                                       input int unsigned g1);
      return pair_e'({parity(r & g0), parity(r & g1)});
   endfunction

endpackage

// File: rtl/bm_pair_calc.sv
// Metrics for the four possible expected code pairs of one received symbol,
// packed with pair {c0,c1} as the slice index.
module bm_pair_calc #(
   parameter int unsigned SOFT_W = viterbi_pkg::SOFT_W,
   parameter int unsigned BM_W   = SOFT_W + 1
) (
   input  logic [SOFT_W-1:0] sym0,
   input  logic [SOFT_W-1:0] sym1,
   input  logic              soft_mode,
   output logic [4*BM_W-1:0] pm
);

   logic [1:0]        pv;
   logic [SOFT_W-1:0] d0;
   logic [SOFT_W-1:0] d1;
   logic [BM_W-1:0]   sum;

   always_comb begin
      pm  = '0;
      pv  = '0;
      d0  = '0;
      d1  = '0;
      sum = '0;
      for (int unsigned p = 0; p < 4; p++) begin
         pv = 2'(p);
         // Distance to an expected 1 is max - x, i.e. the bitwise inverse.
         d0 = pv[1] ? ~sym0 : sym0;
         d1 = pv[0] ? ~sym1 : sym1;
         if (soft_mode)
            sum = BM_W'(d0) + BM_W'(d1);
         else
            sum = BM_W'(sym0[0] ^ pv[1]) + BM_W'(sym1[0] ^ pv[0]);
         pm[p*BM_W +: BM_W] = sum;
      end
   end

endmodule

// File: rtl/bmu_param.sv
// Branch metric unit: two-stage pipeline turning received symbol pairs into
// per-branch metrics, source-state reachability and a frame symbol index.
module bmu_param #(
   parameter int unsigned K      = viterbi_pkg::K,
   parameter int unsigned G0     = viterbi_pkg::G0,
   parameter int unsigned G1     = viterbi_pkg::G1,
   parameter int unsigned SOFT_W = viterbi_pkg::SOFT_W
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   refresh,
   input  logic                                   soft_mode,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [SOFT_W-1:0]                      in_sym0,
   input  logic [SOFT_W-1:0]                      in_sym1,
   input  logic                                   in_first,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [2*(1<<(K-1))*(SOFT_W+1)-1:0]     out_bm,
   output logic [2*(1<<(K-1))-1:0]                out_reach,
   output logic [15:0]                            out_idx
);

   localparam int unsigned BM_W = SOFT_W + 1;
   localparam int unsigned NS   = 1 << (K - 1);

   logic                 s1_valid;
   logic [4*BM_W-1:0]    s1_pm;
   logic [15:0]          s1_idx;
   logic                 s1_mode;

   logic [15:0]          frame_cnt;
   logic                 frame_open;

   logic                 s2_load;
   logic                 s1_load;
   logic                 accept;
   logic                 first_eff;
   logic [15:0]          idx_new;
   logic [4*BM_W-1:0]    pm;

   logic [2*NS*BM_W-1:0] bm_next;
   logic [2*NS-1:0]      reach_next;
   logic                 reach_s;
   viterbi_pkg::pair_e   pr;
   logic [BM_W-1:0]      metric;

   bm_pair_calc #(
      .SOFT_W (SOFT_W),
      .BM_W   (BM_W)
   ) u_pair (
      .sym0      (in_sym0),
      .sym1      (in_sym1),
      .soft_mode (soft_mode),
      .pm        (pm)
   );

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = rst && s1_load;
   assign accept   = in_valid && in_ready;

   // A symbol arriving before any frame start since reset/flush opens a frame.
   assign first_eff = in_first || !frame_open;
   assign idx_new   = first_eff           ? '0 :
                      (frame_cnt == '1)   ? '1 : frame_cnt + 16'd1;

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid   <= 1'b0;
         s1_pm      <= '0;
         s1_idx     <= '0;
         s1_mode    <= 1'b0;
         frame_cnt  <= '0;
         frame_open <= 1'b0;
         out_valid  <= 1'b0;
         out_bm     <= '0;
         out_reach  <= '0;
         out_idx    <= '0;
      end else if (refresh) begin
         s1_valid   <= 1'b0;
         out_valid  <= 1'b0;
         frame_cnt  <= '0;
         frame_open <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid <= accept;
            if (accept) begin
               s1_pm      <= pm;
               s1_idx     <= idx_new;
               s1_mode    <= soft_mode;
               frame_cnt  <= idx_new;
               frame_open <= 1'b1;
            end
         end
         if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
               out_bm    <= bm_next;
               out_reach <= reach_next;
               out_idx   <= s1_idx;
            end
         end
      end
   end

   // Branch j = {s, b}; its metric is the S1 pair metric for the code pair
   // that register value would emit.
   always_comb begin
      bm_next    = '0;
      reach_next = '0;
      reach_s    = 1'b0;
      pr         = viterbi_pkg::PAIR_00;
      metric     = '0;
      for (int unsigned s = 0; s < NS; s++) begin
         reach_s = (32'(s1_idx) >= K - 1) || ((s >> s1_idx) == 0);
         for (int unsigned b = 0; b < 2; b++) begin
            pr     = viterbi_pkg::code_pair((s << 1) | b, G0, G1);
            metric = s1_pm[int'(pr)*BM_W +: BM_W];
            if (!s1_mode)
               metric = BM_W'(metric[1:0]);
            bm_next[(2*s+b)*BM_W +: BM_W] = metric;
            reach_next[2*s+b]             = reach_s;
         end
      end
   end

endmodule

// File: tb/tb_bmu_param.sv
// Scoreboard bench for bmu_param at default parameters: directed symbols with
// hand-computed pair metrics, checked by an independent output monitor.
module tb_bmu_param;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        refresh = 1'b0;
   logic        soft_mode = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_first = 1'b0;
   logic        out_ready = 1'b1;
   logic [2:0]  in_sym0 = '0;
   logic [2:0]  in_sym1 = '0;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_bm;
   logic [7:0]  out_reach;
   logic [15:0] out_idx;

   bmu_param dut (
      .clk       (clk),
      .rst       (rst),
      .refresh   (refresh),
      .soft_mode (soft_mode),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sym0   (in_sym0),
      .in_sym1   (in_sym1),
      .in_first  (in_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bm    (out_bm),
      .out_reach (out_reach),
      .out_idx   (out_idx)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] bm;
      logic [7:0]  reach;
      logic [15:0] idx;
      bit          chk_lat;
      int          acc_cyc;
   } exp_t;

   exp_t sbq[$];
   int tests = 0;
   int fails = 0;

   // Directed symbols; pair metrics listed as {00, 01, 10, 11} with pair = {c0,c1}.
   int v_s0[8]    = '{1, 7, 3, 2, 0, 6, 7, 0};
   int v_s1[8]    = '{1, 0, 5, 3, 0, 7, 7, 0};
   bit v_soft[8]  = '{0, 1, 1, 0, 1, 0, 1, 0};
   int v_pm[8][4] = '{'{2, 1, 1, 0}, '{7, 14, 0, 7}, '{8, 5, 9, 6}, '{1, 0, 2, 1},
                      '{0, 7, 7, 14}, '{1, 0, 2, 1}, '{14, 7, 7, 0}, '{0, 1, 1, 2}};
   // Code pair of branch j for G0=7, G1=5.
   int pair_of_j[8] = '{0, 3, 2, 1, 3, 0, 1, 2};

   function automatic logic [31:0] exp_bm(input int v);
      logic [31:0] r;
      r = '0;
      for (int j = 0; j < 8; j++) r[j*4 +: 4] = 4'(v_pm[v][pair_of_j[j]]);
      return r;
   endfunction

   function automatic logic [7:0] exp_reach(input int idx);
      if (idx == 0) return 8'h03;
      if (idx == 1) return 8'h0F;
      return 8'hFF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive_cycle(input int v, input bit first, input int idx,
                              input bit push, input bit lat, output bit acc);
      exp_t e;
      @(negedge clk);
      in_valid  = 1'b1;
      in_sym0   = 3'(v_s0[v]);
      in_sym1   = 3'(v_s1[v]);
      soft_mode = v_soft[v];
      in_first  = first;
      #1;
      acc       = in_ready;
      e.bm      = exp_bm(v);
      e.reach   = exp_reach(idx);
      e.idx     = 16'(idx);
      e.chk_lat = lat;
      e.acc_cyc = cyc;
      @(posedge clk);
      if (acc && push) sbq.push_back(e);
      #1;
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   task automatic send(input int v, input bit first, input int idx,
                       input bit push, input bit lat, output int n);
      bit acc;
      n = 0;
      do begin
         drive_cycle(v, first, idx, push, lat, acc);
         n++;
      end while (!acc && n < 20);
      chk("send_accept", 32'(acc), 32'd1);
   endtask

   task automatic drain();
      int k = 0;
      while (sbq.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      @(negedge clk);
      chk("drain_empty", 32'(sbq.size()), 32'd0);
   endtask

   // Monitor: consumes one expectation per output transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_output: got idx %0d, expected no output", out_idx);
            end else begin
               e = sbq.pop_front();
               chk("out_bm", out_bm, e.bm);
               chk("out_reach", 32'(out_reach), 32'(e.reach));
               chk("out_idx", 32'(out_idx), 32'(e.idx));
               if (e.chk_lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int pend;
      bit acc;
      int pv[4] = '{1, 2, 3, 4};
      logic [31:0] snap_bm;
      logic [7:0]  snap_reach;
      logic [15:0] snap_idx;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_bm", out_bm, 32'd0);
      chk("rst_out_reach", 32'(out_reach), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ready_after_reset", 32'(in_ready), 32'd1);

      // Hard (1,1), frame start
      send(0, 1, 0, 1, 1, n);
      drain();
      // Soft (7,0)
      send(1, 1, 0, 1, 1, n);
      drain();

      // Four back-to-back symbols in one frame
      send(2, 1, 0, 1, 1, n);
      send(3, 0, 1, 1, 1, n);
      chk("stream_no_stall", 32'(n), 32'd1);
      send(4, 0, 2, 1, 1, n);
      chk("stream_no_stall", 32'(n), 32'd1);
      send(5, 0, 3, 1, 1, n);
      chk("stream_no_stall", 32'(n), 32'd1);
      drain();

      // Mid-frame restart
      send(6, 0, 4, 1, 1, n);
      send(7, 1, 0, 1, 1, n);
      send(0, 0, 1, 1, 1, n);
      drain();

      // Backpressure: five cycles offering symbols with out_ready low
      @(negedge clk);
      out_ready = 1'b0;
      pend = 0;
      for (int c = 0; c < 5; c++) begin
         drive_cycle(pv[pend], pend == 0, pend, 1, 0, acc);
         if (acc) pend++;
      end
      chk("bp_accepted", 32'(pend), 32'd2);
      @(negedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      snap_bm    = out_bm;
      snap_reach = out_reach;
      snap_idx   = out_idx;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk("bp_hold_bm", out_bm, snap_bm);
         chk("bp_hold_reach", 32'(out_reach), 32'(snap_reach));
         chk("bp_hold_idx", 32'(out_idx), 32'(snap_idx));
         chk("bp_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      send(pv[2], 0, 2, 1, 0, n);
      send(pv[3], 0, 3, 1, 0, n);
      drain();

      // Refresh with two symbols in flight
      @(negedge clk);
      out_ready = 1'b0;
      send(1, 1, 0, 0, 0, n);
      send(2, 0, 1, 0, 0, n);
      @(negedge clk);
      refresh = 1'b1;
      @(posedge clk);
      #1;
      refresh = 1'b0;
      chk("refresh_out_valid", 32'(out_valid), 32'd0);
      chk("refresh_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      out_ready = 1'b1;
      send(3, 0, 0, 1, 1, n);
      drain();

      // Reset with two symbols in flight
      @(negedge clk);
      out_ready = 1'b0;
      send(5, 1, 0, 0, 0, n);
      send(6, 0, 1, 0, 0, n);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      out_ready = 1'b1;
      send(4, 0, 0, 1, 1, n);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bmu_param.md
BMU_PARAM -- requirements
Module: bmu_param

Interface
REQ-001 SHALL have parameter K, default 3: constraint length; NS = 2^(K-1) states.
REQ-002 SHALL have parameter G0, default 3'o7: generator for code bit c0.
REQ-003 SHALL have parameter G1, default 3'o5: generator for code bit c1.
REQ-004 SHALL have parameter SOFT_W, default 3: received sample width; BM_W = SOFT_W+1.
REQ-005 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port refresh, input, 1: synchronous flush, active-high.
REQ-008 SHALL have port soft_mode, input, 1: 1 = soft metric, 0 = hard metric; sampled with each accepted symbol.
REQ-009 SHALL have ports in_valid (input, 1) and in_ready (output, 1): input handshake.
REQ-010 SHALL have ports in_sym0 and in_sym1, input, SOFT_W each: received samples for c0 and c1, offset-binary (0 = strong 0, max = strong 1).
REQ-011 SHALL have port in_first, input, 1: the accepted symbol starts a new frame.
REQ-012 SHALL have ports out_valid (output, 1) and out_ready (input, 1): output handshake.
REQ-013 SHALL have port out_bm, output, 2*NS*BM_W: branch metrics; slice j = 2*s+b is the branch from state s with input bit b.
REQ-014 SHALL have port out_reach, output, 2*NS: bit j is 1 when branch j's source state is reachable.
REQ-015 SHALL have port out_idx, output, 16: symbol index within the frame.

Function
REQ-016 SHALL transfer a symbol when in_valid and in_ready are both 1, and SHALL transfer an output when out_valid and out_ready are both 1.
REQ-017 SHALL use a 2-stage pipeline.
- S1 registers the four distinct pair metrics (expected 00/01/10/11), the frame index and the mode.
- S2 registers out_bm, out_reach and out_idx.
REQ-018 SHALL give 2-cycle latency from input transfer to out_valid when out_ready is held at 1, and SHALL sustain 1 symbol per cycle.
REQ-019 SHALL advance the pipeline as follows.
- S2 loads when !out_valid || out_ready.
- S1 loads when !s1_valid || S2 loads.
- in_ready = !s1_valid || S2 loads; a combinational path from out_ready to in_ready is permitted.
REQ-020 SHALL hold out_bm, out_reach and out_idx stable while out_valid=1 and out_ready=0.
REQ-021 SHALL form the branch register r = {s, b}, with b the LSB; expected code bit ci = XOR-reduce(r & Gi); next state = {s[K-3:0], b}.
REQ-022 SHALL compute the hard metric, when soft_mode=0, as (in_sym0[0] != c0) + (in_sym1[0] != c1), range 0..2.
REQ-023 SHALL compute the soft metric, when soft_mode=1, as d(in_sym0, c0) + d(in_sym1, c1), where d(x,0) = x and d(x,1) = (2^SOFT_W-1) - x; the sum never overflows BM_W.
REQ-024 SHALL set out_idx = 0 for a symbol accepted with in_first=1, otherwise previous index + 1, saturating at 16'hFFFF.
REQ-025 SHALL set out_reach bit j = 1 iff out_idx >= K-1 or s < 2^out_idx.
REQ-026 SHALL treat a symbol accepted before any in_first since reset or refresh as in_first=1.
REQ-027 SHALL give refresh priority over any transfer in the same cycle: the transfer is discarded, both stages are emptied and the frame index is cleared.

Reset
REQ-028 SHALL, when rst=0 at a clock edge, clear out_valid, S1 valid, out_bm, out_reach, out_idx and the frame counter to 0, and discard in-flight symbols.
REQ-029 SHALL hold in_ready at 0 during reset and drive it to 1 in the first cycle after release.

Structure
REQ-030 SHALL place K, G0, G1, SOFT_W, BM_W, and functions for parity and expected code pair, in shared package viterbi_pkg.
REQ-031 SHALL use a single sub-module, bm_pair_calc, computing the four pair metrics from (in_sym0, in_sym1, soft_mode).

Verification
REQ-032 SHALL cover this case: defaults, hard mode, in_first=1, sym=(1,1), out_ready=1 -> out_valid 2 cycles later; slice0 = 2, slice1 = 0; out_reach = 8'b0000_0011; out_idx = 0.
REQ-033 SHALL cover this case: soft mode, sym=(7,0) -> pair metric for expected 00 = 7, 11 = 7, 10 = 0, 01 = 14; branch (s=1, b=0) = 0.
REQ-034 SHALL cover this case: 4 consecutive symbols in one frame -> out_reach = 0x03, 0x0F, 0xFF, 0xFF; out_idx = 0, 1, 2, 3.
REQ-035 SHALL cover this case: out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 symbols accepted, in_ready=0 afterwards; outputs stable; no loss or duplication after release.
REQ-036 SHALL cover this case: refresh or rst=0 asserted with 2 symbols in flight -> out_valid=0 the next cycle; the next symbol without in_first reports out_idx = 0.
REQ-037 SHALL cover this case: in_first asserted mid-frame -> out_idx returns to 0 and out_reach to 0x03 for that symbol.
